fifo_write_arbiter: RTL

//  Shares the single write port of one fifo instance among NUM_REQ producers.

---
 rtl/fifo_write_arbiter_pkg.sv | 23 ++
 rtl/fifo_write_arbiter_rr_picker.sv | 35 +++
 rtl/fifo_write_arbiter.sv | 135 +++++++++++++
 3 files changed

// File: rtl/fifo_write_arbiter_pkg.sv
// Shared definitions for the fifo write arbiter and future fifo controllers.
//  state_e : two-state controller encoding (StIdle = 0, StOwn = 1).
//  clog2   : ceiling log2, usable in constant (parameter) context.
package fifo_write_arbiter_pkg;

  typedef enum logic {
    StIdle = 1'b0,
    StOwn  = 1'b1
  } state_e;

  // Smallest r with 2**r >= value; returns 0 for value <= 1.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int i = 0; i < 32; i++) begin
      if ((64'(1) << i) < 64'(value)) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/fifo_write_arbiter_rr_picker.sv
// Combinational round-robin picker.
//  req   : request vector, one bit per producer.
//  start : index where the scan begins (wraps modulo NUM_REQ).
//  any   : at least one request is set.
//  idx   : first set request at or after start, modulo NUM_REQ.
module fifo_write_arbiter_rr_picker #(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   start,
  output logic               any,
  output logic [IDX_W-1:0]   idx
);

  int unsigned pos;

  // Scan from the far end back towards start so the closest hit is written last.
  always_comb begin
    any = 1'b0;
    idx = '0;
    pos = 0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      pos = int'(start) + i;
      if (pos >= NUM_REQ) begin
        pos = pos - NUM_REQ;
      end
      if (req[pos]) begin
        any = 1'b1;
        idx = IDX_W'(pos);
      end
    end
  end

endmodule

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter sharing one fifo write port among NUM_REQ producers,
// with bursts of at most BURST beats per grant and back-pressure from in_full.
//  in_clock  : clock, rising edge.
//  in_reset  : asynchronous reset, active low.
//  in_req    : per-producer request, held while a beat is offered.
//  in_data   : producer k's beat in [k*DATA_WIDTH +: DATA_WIDTH].
//  in_full   : fifo full flag.
//  out_put   : fifo write strobe.
//  out_data  : beat written to the fifo (0 when idle).
//  out_ack   : one-hot, producer's beat consumed at this edge.
//  out_grant : one-hot registered owner, zero when idle.
//  out_busy  : an owner holds the port.
module fifo_write_arbiter
  import fifo_write_arbiter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned BURST      = 4
) (
  input  logic                          in_clock,
  input  logic                          in_reset,
  input  logic [NUM_REQ-1:0]            in_req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] in_data,
  input  logic                          in_full,
  output logic                          out_put,
  output logic [DATA_WIDTH-1:0]         out_data,
  output logic [NUM_REQ-1:0]            out_ack,
  output logic [NUM_REQ-1:0]            out_grant,
  output logic                          out_busy
);

  localparam int unsigned IdxW = clog2(NUM_REQ);
  localparam int unsigned CntW = clog2(BURST + 1);
  localparam logic [IdxW-1:0] LastIdx  = IdxW'(NUM_REQ - 1);
  localparam logic [CntW-1:0] BurstCnt = CntW'(BURST);

  state_e          state_q, state_d;
  logic [IdxW-1:0] owner_q, owner_d;
  logic [IdxW-1:0] last_q, last_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic [IdxW-1:0] scan_base;
  logic [IdxW-1:0] scan_start;
  logic [IdxW-1:0] pick_idx;
  logic            pick_any;
  logic            owner_req;
  logic            put;
  logic [CntW-1:0] cnt_inc;
  logic            release_own;

  // In IDLE the scan follows the last owner; in OWN it follows the current
  // owner, which equals last once release happens, so one picker serves both.
  always_comb begin
    scan_base  = (state_q == StOwn) ? owner_q : last_q;
    scan_start = (scan_base == LastIdx) ? '0 : scan_base + 1'b1;
  end

  fifo_write_arbiter_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IdxW)
  ) u_picker (
    .req   (in_req),
    .start (scan_start),
    .any   (pick_any),
    .idx   (pick_idx)
  );

  always_comb begin
    owner_req   = in_req[owner_q];
    put         = (state_q == StOwn) && owner_req && !in_full;
    cnt_inc     = cnt_q + 1'b1;
    release_own = !owner_req || (put && (cnt_inc == BurstCnt));
  end

  always_comb begin
    out_put   = put;
    out_busy  = (state_q == StOwn);
    out_ack   = '0;
    out_grant = '0;
    out_data  = '0;
    if (state_q == StOwn) begin
      out_grant[owner_q] = 1'b1;
      out_data           = in_data[int'(owner_q) * DATA_WIDTH +: DATA_WIDTH];
    end
    if (put) begin
      out_ack[owner_q] = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (pick_any) begin
          state_d = StOwn;
          owner_d = pick_idx;
          cnt_d   = '0;
        end
      end
      StOwn: begin
        if (put) begin
          cnt_d = cnt_inc;
        end
        if (release_own) begin
          last_d = owner_q;
          cnt_d  = '0;
          if (pick_any) begin
            owner_d = pick_idx;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge in_clock or negedge in_reset) begin
    if (!in_reset) begin
      state_q <= StIdle;
      owner_q <= '0;
      last_q  <= LastIdx;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
